// File: rtl/anc_pkg.sv
// Shared encodings and helpers for the ANC output scheduler: channel FSM states
// and the gain width/unity relationship to the ramp length.
package anc_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } ch_state_e;

  localparam int RAMP_SHIFT_DEF = 8;

  // Gain spans 0..2^ramp_shift inclusive, so it needs one bit above the shift.
  function automatic int gain_w(input int ramp_shift);
    return ramp_shift + 1;
  endfunction

  localparam int UNITY_GAIN = 1 << RAMP_SHIFT_DEF;

endpackage

// File: rtl/anc_out_sched_if.sv
// Per-channel bundle between the scheduler top and one channel ramp engine.
// Stream semantics: yn_out is a registered sample refreshed on each frame tick;
// the consumer has no backpressure, so the top's out_valid strobe is the only
// qualifier (one clk, no ready).
interface anc_out_sched_if #(
  parameter int DW = 16
);
  logic                 fault_raw;
  logic signed [DW-1:0] yn_in;
  logic signed [DW-1:0] yn_out;
  logic                 mute;
  logic [2:0]           state;

  modport master (output fault_raw, yn_in, input yn_out, mute, state);
  modport slave  (input fault_raw, yn_in, output yn_out, mute, state);
endinterface

// File: rtl/anc_ch_ramp.sv
// One speaker channel: fault synchronizer and debounce, warm-up/ramp/fault FSM,
// gain counter and the gain multiplier feeding the DAC sample.
module anc_ch_ramp
  import anc_pkg::*;
#(
  parameter int DW         = 16,
  parameter int RAMP_SHIFT = RAMP_SHIFT_DEF,
  parameter int FAULT_DEB  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              enable,
  input  logic              warm_done,
  anc_out_sched_if.slave    bus
);

  localparam int GW  = gain_w(RAMP_SHIFT);
  localparam int PW  = DW + GW;
  localparam int DBW = $clog2(FAULT_DEB + 1);
  localparam logic [GW-1:0] UNITY = {1'b1, {RAMP_SHIFT{1'b0}}};

  logic            fault_s1, fault_s2, fault_deb;
  logic [DBW-1:0]  deb_cnt;
  ch_state_e       state_q, state_n;
  logic [GW-1:0]   gain_q, gain_n;
  logic            force_zero;
  logic signed [DW-1:0] yn_q;
  logic signed [PW-1:0] yn_ext, gain_ext, prod;
  logic            prod_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_s1 <= 1'b0;
      fault_s2 <= 1'b0;
    end else begin
      fault_s1 <= bus.fault_raw;
      fault_s2 <= fault_s1;
    end
  end

  // The counter only runs while the synchronized level disagrees with the
  // debounced one, so any tick that agrees restarts the consecutive count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      fault_deb <= 1'b0;
    end else if (sample_tick) begin
      if (fault_s2 != fault_deb) begin
        if (deb_cnt == DBW'(FAULT_DEB - 1)) begin
          fault_deb <= fault_s2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      gain_q  <= '0;
    end else begin
      state_q <= state_n;
      gain_q  <= gain_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    gain_n     = gain_q;
    force_zero = 1'b0;
    if (fault_deb && state_q != ST_FAULT) begin
      state_n    = ST_FAULT;
      gain_n     = '0;
      force_zero = 1'b1;
    end else if (sample_tick) begin
      case (state_q)
        ST_OFF: begin
          gain_n = '0;
          if (enable && warm_done && !fault_deb) state_n = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            state_n = ST_RAMP_DOWN;
          end else if (gain_q >= UNITY) begin
            gain_n  = UNITY;
            state_n = ST_ON;
          end else begin
            gain_n = gain_q + 1'b1;
            if (gain_n == UNITY) state_n = ST_ON;
          end
        end
        ST_ON: begin
          gain_n = UNITY;
          if (!enable) state_n = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (enable) begin
            state_n = ST_RAMP_UP;
          end else if (gain_q <= GW'(1)) begin
            gain_n  = '0;
            state_n = ST_OFF;
          end else begin
            gain_n = gain_q - 1'b1;
          end
        end
        ST_FAULT: begin
          gain_n = '0;
          if (!fault_deb && !enable) state_n = ST_OFF;
        end
        default: begin
          state_n = ST_OFF;
          gain_n  = '0;
        end
      endcase
    end
  end

  // Gain is at most 2^RAMP_SHIFT, so the shifted product always fits DW.
  assign yn_ext   = {{GW{bus.yn_in[DW-1]}}, bus.yn_in};
  assign gain_ext = {{DW{1'b0}}, gain_q};
  assign prod     = yn_ext * gain_ext;
  assign prod_unused = ^{prod[PW-1:RAMP_SHIFT+DW], prod[RAMP_SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yn_q <= '0;
    end else if (force_zero) begin
      yn_q <= '0;
    end else if (sample_tick) begin
      yn_q <= prod[RAMP_SHIFT +: DW];
    end
  end

  assign bus.yn_out = yn_q;
  assign bus.mute   = (state_q == ST_OFF) || (state_q == ST_FAULT);
  assign bus.state  = state_q;

endmodule

// File: rtl/anc_out_sched.sv
// Two-channel anti-noise output scheduler: shared frame-counted warm-up,
// per-channel ramp engines, and the output strobe toward the DAC.
module anc_out_sched
  import anc_pkg::*;
#(
  parameter int DW         = 16,
  parameter int RAMP_SHIFT = RAMP_SHIFT_DEF,
  parameter int WARMUP     = 1024,
  parameter int FAULT_DEB  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 enable,
  input  logic                 fault1_i,
  input  logic                 fault2_i,
  input  logic signed [DW-1:0] yn1_i,
  input  logic signed [DW-1:0] yn2_i,
  output logic signed [DW-1:0] yn1_o,
  output logic signed [DW-1:0] yn2_o,
  output logic                 out_valid,
  output logic                 mute1,
  output logic                 mute2,
  output logic [2:0]           state1,
  output logic [2:0]           state2
);

  localparam int WW = $clog2(WARMUP + 1);

  logic [WW-1:0] warm_cnt;
  logic          warm_done;

  anc_out_sched_if #(.DW(DW)) ch1_bus ();
  anc_out_sched_if #(.DW(DW)) ch2_bus ();

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (sample_tick && !warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign warm_done = (warm_cnt == WW'(WARMUP));

  // Samples are registered on the tick edge, so the strobe follows one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= sample_tick;
  end

  assign ch1_bus.fault_raw = fault1_i;
  assign ch1_bus.yn_in     = yn1_i;
  assign ch2_bus.fault_raw = fault2_i;
  assign ch2_bus.yn_in     = yn2_i;

  anc_ch_ramp #(.DW(DW), .RAMP_SHIFT(RAMP_SHIFT), .FAULT_DEB(FAULT_DEB)) u_ch1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .enable      (enable),
    .warm_done   (warm_done),
    .bus         (ch1_bus.slave)
  );

  anc_ch_ramp #(.DW(DW), .RAMP_SHIFT(RAMP_SHIFT), .FAULT_DEB(FAULT_DEB)) u_ch2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .enable      (enable),
    .warm_done   (warm_done),
    .bus         (ch2_bus.slave)
  );

  assign yn1_o  = ch1_bus.yn_out;
  assign yn2_o  = ch2_bus.yn_out;
  assign mute1  = ch1_bus.mute;
  assign mute2  = ch2_bus.mute;
  assign state1 = ch1_bus.state;
  assign state2 = ch2_bus.state;

endmodule
